// File: rtl/lpc_io_decoder_if.sv
// LPC I/O decoder signal bundle: host-side LAD/LFRAME# pins and the
// register-file side (index, write strobe/data, read data).
interface lpc_io_decoder_if;
   logic       LpcFrame_n;
   logic [3:0] LadIn;
   logic [7:0] RdData;
   logic [3:0] LadOut;
   logic       LadOe;
   logic [7:0] Addr;
   logic       Wr;
   logic [7:0] DataWr;
   logic [3:0] dbg_state;

   // Decoder side.
   modport slave (
      input  LpcFrame_n,
      input  LadIn,
      input  RdData,
      output LadOut,
      output LadOe,
      output Addr,
      output Wr,
      output DataWr,
      output dbg_state
   );

   // Host / register-file side.
   modport master (
      output LpcFrame_n,
      output LadIn,
      output RdData,
      input  LadOut,
      input  LadOe,
      input  Addr,
      input  Wr,
      input  DataWr,
      input  dbg_state
   );
endinterface

// File: rtl/lpc_io_decoder.sv
// LPC slave front end: decodes I/O read/write cycles hitting a 32-byte window,
// drives SYNC/read data on LAD and strobes writes into the register file.
module lpc_io_decoder #(
   parameter logic [15:0] BASE_ADDR = 16'h0800
) (
   input logic               PciReset,
   input logic               LpcClock,
   lpc_io_decoder_if.slave   bus
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      CYCTYPE = 4'd1,
      ADDR0   = 4'd2,
      ADDR1   = 4'd3,
      ADDR2   = 4'd4,
      ADDR3   = 4'd5,
      WDATA0  = 4'd6,
      WDATA1  = 4'd7,
      HTAR0   = 4'd8,
      HTAR1   = 4'd9,
      SYNC    = 4'd10,
      RDATA0  = 4'd11,
      RDATA1  = 4'd12,
      PTAR0   = 4'd13,
      PTAR1   = 4'd14
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:4] io_addr;
   logic [15:0] cur_addr;
   logic        window_hit;
   logic        cyc_valid;
   logic        is_write;
   logic [7:0]  rd_latch;
   logic [7:0]  addr_q;
   logic [7:0]  data_wr_q;
   logic        wr_q;
   logic [3:0]  lad_out;
   logic        lad_oe;

   // Full address as seen while the last address nibble is on LAD.
   assign cur_addr   = {io_addr, bus.LadIn};
   assign window_hit = (cur_addr[15:5] == BASE_ADDR[15:5]);
   assign cyc_valid  = (bus.LadIn[3:1] == 3'b000) || (bus.LadIn[3:1] == 3'b001);

   always_ff @(posedge LpcClock or negedge PciReset) begin
      if (!PciReset) begin
         state     <= IDLE;
         io_addr   <= '0;
         is_write  <= 1'b0;
         rd_latch  <= 8'h00;
         addr_q    <= 8'h00;
         data_wr_q <= 8'h00;
         wr_q      <= 1'b0;
      end else begin
         state <= state_next;
         // Wr is high for exactly the clock spent in SYNC of a write cycle.
         wr_q  <= (state_next == SYNC) && is_write;
         if (state == HTAR1) begin
            rd_latch <= bus.RdData;
         end
         if (bus.LpcFrame_n) begin
            case (state)
               CYCTYPE: is_write        <= bus.LadIn[1];
               ADDR0:   io_addr[15:12]  <= bus.LadIn;
               ADDR1:   io_addr[11:8]   <= bus.LadIn;
               ADDR2:   io_addr[7:4]    <= bus.LadIn;
               ADDR3: begin
                  if (window_hit) begin
                     addr_q <= {3'b000, cur_addr[4:0]};
                  end
               end
               WDATA0:  data_wr_q[3:0]  <= bus.LadIn;
               WDATA1:  data_wr_q[7:4]  <= bus.LadIn;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_next = state;
      if (!bus.LpcFrame_n) begin
         state_next = (bus.LadIn == 4'b0000) ? CYCTYPE : IDLE;
      end else begin
         case (state)
            IDLE:    state_next = IDLE;
            CYCTYPE: state_next = cyc_valid ? ADDR0 : IDLE;
            ADDR0:   state_next = ADDR1;
            ADDR1:   state_next = ADDR2;
            ADDR2:   state_next = ADDR3;
            ADDR3: begin
               if (!window_hit) begin
                  state_next = IDLE;
               end else if (is_write) begin
                  state_next = WDATA0;
               end else begin
                  state_next = HTAR0;
               end
            end
            WDATA0:  state_next = WDATA1;
            WDATA1:  state_next = HTAR0;
            HTAR0:   state_next = HTAR1;
            HTAR1:   state_next = SYNC;
            SYNC:    state_next = is_write ? PTAR0 : RDATA0;
            RDATA0:  state_next = RDATA1;
            RDATA1:  state_next = PTAR0;
            PTAR0:   state_next = PTAR1;
            PTAR1:   state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // LAD drive depends on the state register alone, so reset releases it at once.
   always_comb begin
      lad_oe  = 1'b0;
      lad_out = 4'b1111;
      case (state)
         SYNC: begin
            lad_oe  = 1'b1;
            lad_out = 4'b0000;
         end
         RDATA0: begin
            lad_oe  = 1'b1;
            lad_out = rd_latch[3:0];
         end
         RDATA1: begin
            lad_oe  = 1'b1;
            lad_out = rd_latch[7:4];
         end
         PTAR0: begin
            lad_oe  = 1'b1;
            lad_out = 4'b1111;
         end
         default: ;
      endcase
   end

   assign bus.LadOut    = lad_out;
   assign bus.LadOe     = lad_oe;
   assign bus.Addr      = addr_q;
   assign bus.Wr        = wr_q;
   assign bus.DataWr    = data_wr_q;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_lpc_io_decoder.sv
// Directed bench for lpc_io_decoder: writes, reads, window misses, aborts,
// stretched START, reset mid-cycle.
module tb_lpc_io_decoder;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_WDATA0 = 4'd6;
   localparam logic [3:0] S_HTAR0  = 4'd8;
   localparam logic [3:0] S_SYNC   = 4'd10;
   localparam logic [3:0] S_RDATA0 = 4'd11;
   localparam logic [3:0] S_PTAR1  = 4'd14;

   logic PciReset;
   logic LpcClock;
   int   n_cmp;
   int   n_bad;
   int   oe_hits;
   int   wr_hits;

   lpc_io_decoder_if bus ();

   lpc_io_decoder #(.BASE_ADDR(16'h0800)) dut (
      .PciReset (PciReset),
      .LpcClock (LpcClock),
      .bus      (bus)
   );

   // Register file model: index 0x1F reads 0xA7, others read {index[3:0], 5}.
   assign bus.RdData = (bus.Addr == 8'h1F) ? 8'hA7 : {bus.Addr[3:0], 4'h5};

   initial begin
      LpcClock = 1'b0;
      forever #15 LpcClock = ~LpcClock;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic f, input logic [3:0] l);
      bus.LpcFrame_n = f;
      bus.LadIn      = l;
      @(posedge LpcClock);
      #1;
   endtask

   task automatic header(input logic w, input logic [15:0] a);
      cyc(1'b1, w ? 4'h2 : 4'h0);
      cyc(1'b1, a[15:12]);
      cyc(1'b1, a[11:8]);
      cyc(1'b1, a[7:4]);
      cyc(1'b1, a[3:0]);
   endtask

   task automatic wdata(input logic [7:0] d);
      cyc(1'b1, d[3:0]);
      cyc(1'b1, d[7:4]);
   endtask

   task automatic quiet(input int n, output int oe_n, output int wr_n);
      oe_n = 0;
      wr_n = 0;
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 4'hF);
         if (bus.LadOe) oe_n++;
         if (bus.Wr) wr_n++;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      PciReset       = 1'b0;
      bus.LpcFrame_n = 1'b1;
      bus.LadIn      = 4'hF;
      #100;
      check("rst_state", {4'h0, bus.dbg_state}, {4'h0, S_IDLE});
      check("rst_oe", {7'h0, bus.LadOe}, 8'h00);
      check("rst_lad", {4'h0, bus.LadOut}, 8'h0F);
      check("rst_addr", bus.Addr, 8'h00);
      check("rst_wr", {7'h0, bus.Wr}, 8'h00);
      check("rst_data", bus.DataWr, 8'h00);
      #7 PciReset = 1'b1;
      cyc(1'b1, 4'hF);

      // Write 0x0805 <- 0x3C
      cyc(1'b0, 4'h0);
      header(1'b1, 16'h0805);
      check("w1_st_wdata0", {4'h0, bus.dbg_state}, {4'h0, S_WDATA0});
      check("w1_addr", bus.Addr, 8'h05);
      wdata(8'h3C);
      check("w1_data", bus.DataWr, 8'h3C);
      cyc(1'b1, 4'hF);
      check("w1_htar1_wr", {7'h0, bus.Wr}, 8'h00);
      check("w1_htar1_oe", {7'h0, bus.LadOe}, 8'h00);
      cyc(1'b1, 4'hF);
      check("w1_sync_st", {4'h0, bus.dbg_state}, {4'h0, S_SYNC});
      check("w1_sync_wr", {7'h0, bus.Wr}, 8'h01);
      check("w1_sync_oe", {7'h0, bus.LadOe}, 8'h01);
      check("w1_sync_lad", {4'h0, bus.LadOut}, 8'h00);
      cyc(1'b1, 4'hF);
      check("w1_ptar0_wr", {7'h0, bus.Wr}, 8'h00);
      check("w1_ptar0_oe", {7'h0, bus.LadOe}, 8'h01);
      check("w1_ptar0_lad", {4'h0, bus.LadOut}, 8'h0F);
      cyc(1'b1, 4'hF);
      check("w1_ptar1_oe", {7'h0, bus.LadOe}, 8'h00);
      cyc(1'b1, 4'hF);

      // Read 0x081F, register file returns 0xA7
      cyc(1'b0, 4'h0);
      header(1'b0, 16'h081F);
      check("r1_st_htar0", {4'h0, bus.dbg_state}, {4'h0, S_HTAR0});
      check("r1_addr", bus.Addr, 8'h1F);
      cyc(1'b1, 4'hF);
      check("r1_htar1_oe", {7'h0, bus.LadOe}, 8'h00);
      cyc(1'b1, 4'hF);
      check("r1_sync_oe", {7'h0, bus.LadOe}, 8'h01);
      check("r1_sync_lad", {4'h0, bus.LadOut}, 8'h00);
      check("r1_sync_wr", {7'h0, bus.Wr}, 8'h00);
      cyc(1'b1, 4'hF);
      check("r1_rd0_lad", {4'h0, bus.LadOut}, 8'h07);
      cyc(1'b1, 4'hF);
      check("r1_rd1_lad", {4'h0, bus.LadOut}, 8'h0A);
      cyc(1'b1, 4'hF);
      check("r1_ptar0_lad", {4'h0, bus.LadOut}, 8'h0F);
      check("r1_ptar0_oe", {7'h0, bus.LadOe}, 8'h01);
      cyc(1'b1, 4'hF);
      check("r1_ptar1_oe", {7'h0, bus.LadOe}, 8'h00);
      check("r1_ptar1_st", {4'h0, bus.dbg_state}, {4'h0, S_PTAR1});
      cyc(1'b1, 4'hF);

      // Window misses
      cyc(1'b0, 4'h0);
      header(1'b1, 16'h0900);
      check("m1_state", {4'h0, bus.dbg_state}, {4'h0, S_IDLE});
      quiet(10, oe_hits, wr_hits);
      check("m1_oe", oe_hits[7:0], 8'h00);
      check("m1_wr", wr_hits[7:0], 8'h00);
      check("m1_addr", bus.Addr, 8'h1F);
      cyc(1'b0, 4'h0);
      header(1'b0, 16'h0820);
      check("m2_state", {4'h0, bus.dbg_state}, {4'h0, S_IDLE});
      quiet(10, oe_hits, wr_hits);
      check("m2_oe", oe_hits[7:0], 8'h00);
      check("m2_addr", bus.Addr, 8'h1F);

      // Abort during ADDR2 of a write to 0x0801, then read 0x0801
      cyc(1'b0, 4'h0);
      cyc(1'b1, 4'h2);
      cyc(1'b1, 4'h0);
      cyc(1'b1, 4'h8);
      cyc(1'b0, 4'hF);
      check("ab_state", {4'h0, bus.dbg_state}, {4'h0, S_IDLE});
      quiet(12, oe_hits, wr_hits);
      check("ab_wr", wr_hits[7:0], 8'h00);
      check("ab_oe", oe_hits[7:0], 8'h00);
      cyc(1'b0, 4'h0);
      header(1'b0, 16'h0801);
      check("ab_r_addr", bus.Addr, 8'h01);
      cyc(1'b1, 4'hF);
      cyc(1'b1, 4'hF);
      check("ab_r_sync", {3'h0, bus.LadOe, bus.LadOut}, 8'h10);
      cyc(1'b1, 4'hF);
      check("ab_r_rd0", {4'h0, bus.LadOut}, 8'h05);
      cyc(1'b1, 4'hF);
      check("ab_r_rd1", {4'h0, bus.LadOut}, 8'h01);
      cyc(1'b1, 4'hF);
      cyc(1'b1, 4'hF);
      cyc(1'b1, 4'hF);

      // Stretched START (3 low clocks), write 0x0808 <- 0x40
      cyc(1'b0, 4'h3);
      cyc(1'b0, 4'hF);
      cyc(1'b0, 4'h0);
      header(1'b1, 16'h0808);
      wdata(8'h40);
      cyc(1'b1, 4'hF);
      check("st_pre_wr", {7'h0, bus.Wr}, 8'h00);
      cyc(1'b1, 4'hF);
      check("st_sync_st", {4'h0, bus.dbg_state}, {4'h0, S_SYNC});
      check("st_sync_wr", {7'h0, bus.Wr}, 8'h01);
      check("st_addr", bus.Addr, 8'h08);
      check("st_data", bus.DataWr, 8'h40);
      cyc(1'b1, 4'hF);
      cyc(1'b1, 4'hF);
      cyc(1'b1, 4'hF);

      // Non-0000 start code is ignored
      cyc(1'b0, 4'h2);
      check("bs_state", {4'h0, bus.dbg_state}, {4'h0, S_IDLE});
      cyc(1'b1, 4'h2);
      cyc(1'b1, 4'h0);
      cyc(1'b1, 4'h8);
      cyc(1'b1, 4'h0);
      cyc(1'b1, 4'h1);
      check("bs_state2", {4'h0, bus.dbg_state}, {4'h0, S_IDLE});
      quiet(8, oe_hits, wr_hits);
      check("bs_wr", wr_hits[7:0], 8'h00);
      check("bs_addr", bus.Addr, 8'h08);

      // Abort during SYNC of a write to 0x0802 <- 0x55
      cyc(1'b0, 4'h0);
      header(1'b1, 16'h0802);
      wdata(8'h55);
      cyc(1'b1, 4'hF);
      cyc(1'b1, 4'hF);
      check("as_sync_wr", {7'h0, bus.Wr}, 8'h01);
      cyc(1'b0, 4'hF);
      check("as_oe", {7'h0, bus.LadOe}, 8'h00);
      check("as_wr", {7'h0, bus.Wr}, 8'h00);
      check("as_state", {4'h0, bus.dbg_state}, {4'h0, S_IDLE});
      check("as_data", bus.DataWr, 8'h55);
      quiet(4, oe_hits, wr_hits);
      check("as_wr_after", wr_hits[7:0], 8'h00);

      // Reset asserted during RDATA0
      cyc(1'b0, 4'h0);
      header(1'b0, 16'h081F);
      cyc(1'b1, 4'hF);
      cyc(1'b1, 4'hF);
      cyc(1'b1, 4'hF);
      check("rr_rd0_st", {4'h0, bus.dbg_state}, {4'h0, S_RDATA0});
      check("rr_rd0_oe", {7'h0, bus.LadOe}, 8'h01);
      #5 PciReset = 1'b0;
      #1;
      check("rr_oe", {7'h0, bus.LadOe}, 8'h00);
      check("rr_lad", {4'h0, bus.LadOut}, 8'h0F);
      check("rr_addr", bus.Addr, 8'h00);
      check("rr_data", bus.DataWr, 8'h00);
      check("rr_state", {4'h0, bus.dbg_state}, {4'h0, S_IDLE});
      #5 PciReset = 1'b1;
      cyc(1'b1, 4'hF);
      cyc(1'b0, 4'h0);
      header(1'b1, 16'h0804);
      wdata(8'h1B);
      cyc(1'b1, 4'hF);
      cyc(1'b1, 4'hF);
      check("pr_sync_wr", {7'h0, bus.Wr}, 8'h01);
      check("pr_addr", bus.Addr, 8'h04);
      check("pr_data", bus.DataWr, 8'h1B);
      check("pr_sync_lad", {3'h0, bus.LadOe, bus.LadOut}, 8'h10);
      cyc(1'b1, 4'hF);
      check("pr_ptar0_wr", {7'h0, bus.Wr}, 8'h00);
      cyc(1'b1, 4'hF);
      cyc(1'b1, 4'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
